div_dispatch: RTL
=================

DIV_DISPATCH -- requirements
Module: div_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result bit width.
REQ-002 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two).
REQ-003 SHALL have clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have in_valid  input  1  operand pair offered.
REQ-006 SHALL have in_ready  output  1  FIFO not full.
REQ-007 SHALL have in_x, in_y  input  WIDTH  dividend, divisor.
REQ-008 SHALL have div_start  output  1  one-cycle start pulse to divider.
REQ-009 SHALL have div_x, div_y  output  WIDTH  operands to divider.
REQ-010 SHALL have div_valid  input  1  divider done level.
REQ-011 SHALL have div_quot, div_rem  input  WIDTH  divider results.
REQ-012 SHALL have out_valid  output  1  result held.
REQ-013 SHALL have out_ready  input  1  consumer accepts.
REQ-014 SHALL have out_quot, out_rem  output  WIDTH  result.
REQ-015 SHALL have out_dbz  output  1  divide-by-zero flag for held result.
REQ-016 SHALL have busy  output  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; in_valid while full is ignored, no overwrite.
REQ-018 FIFO SHALL support simultaneous push and pop in one cycle, including when full (pop frees slot next cycle only; in_ready from registered count).
REQ-019 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-021 IDLE: if FIFO non-empty and out_valid==0: head y==0 -> pop, load out_quot=all ones, out_rem=x, out_dbz=1, out_valid=1, stay IDLE, no div_start; else latch head into div_x/div_y, go ISSUE.
REQ-022 ISSUE: div_start=1 for exactly one cycle, pop FIFO, go WAIT.
REQ-023 Completion SHALL be the rising edge of div_valid (div_valid && !div_valid_q), detected only in WAIT; edges in other states are ignored.
REQ-024 WAIT on completion: capture div_quot/div_rem into out_quot/out_rem, out_dbz=0, out_valid=1, go IDLE.
REQ-025 div_x/div_y SHALL stay stable from ISSUE until leaving WAIT.
REQ-026 out_valid SHALL clear on out_valid && out_ready; outputs hold value while out_valid && !out_ready.
REQ-027 Results SHALL emerge in push order; at most one operation outstanding.
REQ-028 Dispatch latency: FIFO push to div_start = 2 cycles minimum (push, IDLE, ISSUE).
REQ-029 Arithmetic: no width growth; results passed through unmodified.

Reset
REQ-030 On rst low: FIFO empty, pointers/count 0, state IDLE, div_start 0, div_x/div_y 0, div_valid_q 0, out_valid 0, out_quot/out_rem 0, out_dbz 0, in_ready 1, busy 0.
REQ-031 Reset mid-WAIT SHALL abandon the operation; a later div_valid edge after release SHALL be ignored since state is IDLE.
REQ-032 Reset deassertion SHALL not generate a div_start.

Structure
REQ-033 Package div_pkg SHALL hold WIDTH/DEPTH defaults and the FSM state enum.
REQ-034 FIFO SHALL be sub-module div_op_fifo (storage of {x,y}, pointers, count, full/empty).
REQ-035 Estimated size 150-250 RTL lines.

Verification
REQ-036 Push 15/8, divider model returns after 6 cycles -> one div_start with div_x=15, div_y=8; out_quot=1, out_rem=7, out_dbz=0.
REQ-037 Push 10/2 after first result drained -> out_quot=5, out_rem=0, single start pulse.
REQ-038 Push 9/0 -> no div_start; out_quot=15, out_rem=9, out_dbz=1 within 2 cycles.
REQ-039 Push 5 pairs back-to-back with out_ready=1 -> 5th rejected (in_ready=0) until first pop; 4 results in push order.
REQ-040 Hold out_ready=0 for 20 cycles with 2 queued -> first result stable, no further div_start until drained.
REQ-041 Assert rst during WAIT, then divider raises div_valid -> all outputs at reset values, no out_valid.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divider dispatch unit.
// Holds size defaults and the dispatch FSM state encoding.
package div_pkg;

    localparam int DIV_WIDTH = 4;
    localparam int DIV_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/div_dispatch_if.sv
// Bundle of the operand stream, divider port and result stream.
// slave is the dispatcher side, master is the environment side.
interface div_dispatch_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;

    logic             div_start;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             div_valid;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;
    logic             out_dbz;

    logic             busy;

    modport slave (
        input  in_valid, in_x, in_y,
        output in_ready,
        output div_start, div_x, div_y,
        input  div_valid, div_quot, div_rem,
        output out_valid, out_quot, out_rem, out_dbz,
        input  out_ready,
        output busy
    );

    modport master (
        output in_valid, in_x, in_y,
        input  in_ready,
        input  div_start, div_x, div_y,
        output div_valid, div_quot, div_rem,
        input  out_valid, out_quot, out_rem, out_dbz,
        output out_ready,
        input  busy
    );

endinterface

// File: rtl/div_op_fifo.sv
// Operand FIFO holding {x,y} pairs for the divider dispatcher.
// DEPTH must be a power of two (>=2) so pointers wrap naturally.
module div_op_fifo
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = DIV_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] head_x_o,
    output logic [WIDTH-1:0] head_y_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_x_q [DEPTH];
    logic [WIDTH-1:0] mem_y_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o   = (cnt_q == CW'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign head_x_o = mem_x_q[rptr_q];
    assign head_y_o = mem_y_q[rptr_q];

    // Next pointers and occupancy; push and pop may coincide.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Operand storage, written at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i] <= '0;
                mem_y_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_x_q[wptr_q] <= x_i;
            mem_y_q[wptr_q] <= y_i;
        end
    end

endmodule

// File: rtl/div_dispatch.sv
// Queues operand pairs and issues them one at a time to a divider.
// Divide-by-zero is answered locally without starting the divider.
module div_dispatch
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = DIV_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    div_dispatch_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ov_q, ov_d;
    logic             dv_q;

    logic [WIDTH-1:0] head_x;
    logic [WIDTH-1:0] head_y;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             start;
    logic             done;

    assign push = bus.in_valid && !full;
    assign done = bus.div_valid && !dv_q;

    div_op_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .pop_i    (pop),
        .x_i      (bus.in_x),
        .y_i      (bus.in_y),
        .head_x_o (head_x),
        .head_y_o (head_y),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Dispatch FSM: next state, operand latch, result load, pop.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ov_d    = ov_q;
        pop     = 1'b0;
        start   = 1'b0;
        if (ov_q && bus.out_ready) ov_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !ov_q) begin
                    if (head_y == '0) begin
                        pop    = 1'b1;
                        quot_d = '1;
                        rem_d  = head_x;
                        dbz_d  = 1'b1;
                        ov_d   = 1'b1;
                    end else begin
                        x_d     = head_x;
                        y_d     = head_y;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                start   = 1'b1;
                pop     = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    quot_d  = bus.div_quot;
                    rem_d   = bus.div_rem;
                    dbz_d   = 1'b0;
                    ov_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ov_q    <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ov_q    <= ov_d;
            dv_q    <= bus.div_valid;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.div_start = start;
    assign bus.div_x     = x_q;
    assign bus.div_y     = y_q;
    assign bus.out_valid = ov_q;
    assign bus.out_quot  = quot_q;
    assign bus.out_rem   = rem_q;
    assign bus.out_dbz   = dbz_q;
    assign bus.busy      = (state_q != S_IDLE) || !empty;

endmodule
